// File: rtl/booth_result_fifo.sv
// booth_result_fifo
// Captures one product per rising edge of the multiplier's done level and
// buffers it in a first-word-fall-through FIFO. The block also keeps a signed
// running sum of every captured product.
//
// Handshake (consumer side): the head entry is on m_data whenever m_valid=1.
// A word is transferred on a clk edge where m_valid=1 and m_ready=1. m_valid
// does not depend combinationally on m_ready, and m_data stays stable until
// that word is transferred. The producer side has no backpressure: a capture
// that finds the FIFO full with no pop in the same cycle is dropped, and the
// sticky overflow flag is set.
module booth_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int ACC_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     done,
    input  logic [WIDTH-1:0]         product,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [ACC_W-1:0]         acc,
    input  logic                     acc_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             done_d;
    logic             overflow_q;
    logic [ACC_W-1:0] acc_q;

    logic             cap;
    logic             pop;
    logic             push;
    logic             drop;
    logic [ACC_W-1:0] prod_ext;

    // Status and handshake decode, all derived from the registered occupancy
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign m_valid  = ~empty;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign acc      = acc_q;

    assign cap      = done & ~done_d;
    assign pop      = m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push     = cap & (~full | pop);
    assign drop     = cap & full & ~pop;
    assign prod_ext = ACC_W'($signed(product));

    // FWFT head: show the oldest entry, forced to 0 while empty
    always_comb begin
        m_data = '0;
        if (!empty) begin
            m_data = mem[rd_ptr];
        end
    end

    // Edge detector register. It keeps sampling during reset so that a done
    // level still high at reset release is not taken for a new edge.
    always_ff @(posedge clk) begin
        done_d <= done;
    end

    // Storage array, written on every accepted capture
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= product;
        end
    end

    // Pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle wins over a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // Running sum over all captures, including dropped ones; wraps modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (cap) begin
            if (acc_clr) begin
                acc_q <= prod_ext;
            end else begin
                acc_q <= acc_q + prod_ext;
            end
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

endmodule
